// File: rtl/data_mem_responder.sv
// Data-memory responder: synchronous word RAM with byte-lane writes, an
// optional wait-state FSM that stalls the core, and an out-of-range flag.
module data_mem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] resp_rdata,
    output logic        resp_valid,
    output logic        busy,
    output logic        addr_err
);

    localparam int unsigned Depth   = 2 ** ADDR_W;
    localparam bit          NoWait  = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CntInit = NoWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    logic [31:0] mem [Depth];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  lat_wen_q, lat_wen_d;
    logic [31:0] lat_addr_q, lat_addr_d;
    logic [31:0] lat_wdata_q, lat_wdata_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        addr_err_q, addr_err_d;

    // Access selected for this edge: straight from the request port with no
    // wait states, otherwise from the latched fields once the count expires.
    logic              acc_go;
    logic [3:0]        acc_wen;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [ADDR_W-1:0] acc_idx;
    logic              acc_in_range;
    logic              unused_addr_lsb;

    // State register, RAM write port and response flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            lat_wen_q    <= 4'd0;
            lat_addr_q   <= 32'd0;
            lat_wdata_q  <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_wen_q    <= lat_wen_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_valid_q <= resp_valid_d;
            addr_err_q   <= addr_err_d;
            if (acc_go && acc_in_range) begin
                for (int i = 0; i < 4; i++) begin
                    if (acc_wen[i]) begin
                        mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Next-state: latch the request in idle, count down wait states.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_wen_d   = lat_wen_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        if (!NoWait) begin
            unique case (state_q)
                StIdle: begin
                    if (req_en) begin
                        lat_wen_d   = req_wen;
                        lat_addr_d  = req_addr;
                        lat_wdata_d = req_wdata;
                        cnt_d       = CntInit;
                        state_d     = StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    // Outputs: access decode, response next values and the stall request.
    always_comb begin
        if (NoWait) begin
            acc_go    = req_en;
            acc_wen   = req_wen;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_go    = (state_q == StWait) && (cnt_q == 4'd0);
            acc_wen   = lat_wen_q;
            acc_addr  = lat_addr_q;
            acc_wdata = lat_wdata_q;
        end
        acc_idx      = acc_addr[ADDR_W+1:2];
        acc_in_range = (acc_addr[31:ADDR_W+2] == '0);

        resp_valid_d = acc_go;
        addr_err_d   = acc_go && !acc_in_range;
        resp_rdata_d = resp_rdata_q;
        if (acc_go) begin
            // Pre-write contents; a partial write still returns the old word.
            resp_rdata_d = acc_in_range ? mem[acc_idx] : 32'd0;
        end

        busy = !NoWait && ((state_q == StWait) || ((state_q == StIdle) && req_en));
    end

    assign unused_addr_lsb = ^acc_addr[1:0];

    assign resp_rdata = resp_rdata_q;
    assign resp_valid = resp_valid_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with no wait states,
// one with three; expected responses come from a word-array memory model.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, req_en0, resp_valid0, busy0, addr_err0;
    logic [3:0]  req_wen0;
    logic [31:0] req_addr0, req_wdata0, resp_rdata0;
    logic        rst3, req_en3, resp_valid3, busy3, addr_err3;
    logic [3:0]  req_wen3;
    logic [31:0] req_addr3, req_wdata3, resp_rdata3;

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .req_en(req_en0), .req_wen(req_wen0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .resp_rdata(resp_rdata0),
        .resp_valid(resp_valid0), .busy(busy0), .addr_err(addr_err0)
    );

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .req_en(req_en3), .req_wen(req_wen3),
        .req_addr(req_addr3), .req_wdata(req_wdata3), .resp_rdata(resp_rdata3),
        .resp_valid(resp_valid3), .busy(busy3), .addr_err(addr_err3)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] model [2][1024];
    logic [32:0] q0 [$];
    logic [32:0] q3 [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference access: {addr_err, rdata}; memory updated after the read.
    task automatic model_acc(input int d, input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [32:0] e);
        int idx;
        if (addr >= 32'h0000_1000) begin
            e = {1'b1, 32'h0};
        end else begin
            idx = int'(addr / 4);
            e = {1'b0, model[d][idx]};
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) model[d][idx][8*i +: 8] = wd[8*i +: 8];
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0)
            return ($urandom & 32'hFFFF_F000) | (32'h1 << $urandom_range(12, 31));
        return 32'h100 + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
    endfunction

    // Monitors: pop and compare whenever a response appears.
    always @(negedge clk) begin
        if (!rst0) begin
            check("dut0_busy_zero", busy0, 0);
            if (addr_err0 && !resp_valid0) begin
                errors++;
                $display("FAIL dut0_err_without_valid: got addr_err=1 expected 0");
            end
            if (resp_valid0) begin
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL dut0_spurious_valid: got resp_valid=1 expected 0");
                end else begin
                    logic [32:0] e;
                    e = q0.pop_front();
                    check("dut0_rdata", resp_rdata0, e[31:0]);
                    check("dut0_addr_err", addr_err0, e[32]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst3) begin
            if (addr_err3 && !resp_valid3) begin
                errors++;
                $display("FAIL dut3_err_without_valid: got addr_err=1 expected 0");
            end
            if (resp_valid3) begin
                if (q3.size() == 0) begin
                    errors++;
                    $display("FAIL dut3_spurious_valid: got resp_valid=1 expected 0");
                end else begin
                    logic [32:0] e;
                    e = q3.pop_front();
                    check("dut3_rdata", resp_rdata3, e[31:0]);
                    check("dut3_addr_err", addr_err3, e[32]);
                end
            end
        end
    end

    // One-cycle request to the zero-wait instance; back-to-back calls stream.
    task automatic issue0(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
        logic [32:0] e;
        req_en0 = 1'b1; req_wen0 = wen; req_addr0 = addr; req_wdata0 = wd;
        model_acc(0, wen, addr, wd, e);
        q0.push_back(e);
        @(posedge clk); #1;
        req_en0 = 1'b0;
        check("dut0_valid_next_cycle", resp_valid0, 1);
    endtask

    // Request to the wait-state instance; optionally scrambles inputs in WAIT.
    task automatic issue3(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd,
                          input bit toggle);
        logic [32:0] e;
        req_en3 = 1'b1; req_wen3 = wen; req_addr3 = addr; req_wdata3 = wd;
        #1;
        check("dut3_busy_req_cycle", busy3, 1);
        model_acc(1, wen, addr, wd, e);
        q3.push_back(e);
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            if (toggle) begin
                req_en3    = 1'($urandom);
                req_wen3   = 4'($urandom_range(1, 15));
                req_addr3  = rand_addr();
                req_wdata3 = $urandom;
            end else begin
                req_en3 = 1'b0;
            end
            #1;
            check("dut3_busy_wait", busy3, 1);
            check("dut3_no_early_valid", resp_valid3, 0);
            @(posedge clk); #1;
        end
        req_en3 = 1'b0;
        #1;
        check("dut3_busy_resp_cycle", busy3, 0);
        check("dut3_valid_at_w_plus_1", resp_valid3, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; rst3 = 1'b1;
        req_en0 = 0; req_wen0 = 0; req_addr0 = 0; req_wdata0 = 0;
        req_en3 = 0; req_wen3 = 0; req_addr3 = 0; req_wdata3 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata0", resp_rdata0, 0);
        check("reset_valid0", resp_valid0, 0);
        check("reset_err0", addr_err0, 0);
        check("reset_rdata3", resp_rdata3, 0);
        check("reset_valid3", resp_valid3, 0);
        check("reset_err3", addr_err3, 0);
        check("reset_busy3", busy3, 0);
        rst0 = 1'b0; rst3 = 1'b0;
        idle(1);

        // Known contents for every word the bench reads.
        for (int w = 0; w < 16; w++) issue0(4'hF, 32'h100 + w * 4, $urandom);
        for (int w = 0; w < 4; w++) issue0(4'hF, w * 4, 32'hA5000000 + w);
        for (int w = 0; w < 16; w++) issue3(4'hF, 32'h100 + w * 4, $urandom, 0);
        issue3(4'hF, 32'h0, 32'h0BADF00D, 0);
        issue3(4'hF, 32'h20, 32'h11112222, 0);

        // Full write then read-back, then a single-lane write via 0x13.
        issue0(4'hF, 32'h10, 32'hDEADBEEF);
        issue0(4'h0, 32'h10, 32'h0);
        issue0(4'b0010, 32'h13, 32'h0000AB00);
        issue0(4'h0, 32'h10, 32'h0);
        idle(2);
        issue3(4'hF, 32'h10, 32'hDEADBEEF, 0);
        issue3(4'b0010, 32'h13, 32'h0000AB00, 0);

        // Wait-state read with inputs scrambled during WAIT, then re-read.
        issue3(4'h0, 32'h10, 32'h0, 1);
        issue3(4'h0, 32'h10, 32'h0, 0);

        // Out-of-range write must not alias onto word 0.
        issue0(4'hF, 32'h0000_1000, 32'h12345678);
        issue0(4'h0, 32'h0, 32'h0);
        issue3(4'hF, 32'h0000_1000, 32'h12345678, 0);
        issue3(4'h0, 32'h0, 32'h0, 0);

        // Reset on the second WAIT cycle discards the pending write.
        req_en3 = 1'b1; req_wen3 = 4'hF; req_addr3 = 32'h20; req_wdata3 = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_en3 = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        #1;
        check("rst_mid_busy", busy3, 0);
        check("rst_mid_valid", resp_valid3, 0);
        check("rst_mid_err", addr_err3, 0);
        idle(2);
        issue3(4'h0, 32'h20, 32'h0, 0);

        // Streaming reads, one response per cycle.
        idle(1);
        for (int w = 0; w < 4; w++) issue0(4'h0, w * 4, 32'h0);

        // Randomized traffic over the initialized region plus out-of-range.
        for (int n = 0; n < 60; n++) begin
            issue0(4'($urandom_range(0, 15)), rand_addr(), $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        for (int n = 0; n < 30; n++) begin
            issue3(4'($urandom_range(0, 15)), rand_addr(), $urandom, 1'($urandom));
        end

        idle(6);
        check("dut0_all_responses_seen", q0.size(), 0);
        check("dut3_all_responses_seen", q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the datapath's data-memory port.
- Accepts the core's word address, 4-bit byte-lane write strobe and write data, and returns read data.
- Backing store is a synchronous word RAM with byte-lane writes.
- A wait-state counter models slow memory; `busy` feeds the hazard unit as a stall source alongside the divider stall.

Parameters:
- ADDR_W, 10, word-address bits; RAM depth is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 0, extra wait states per access; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_en  in  1  access request, sampled each rising edge.
- req_wen  in  4  byte-lane write strobe; bit i writes wdata[8i+7:8i]; 0000 means read.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data, already lane-aligned by the core.
- resp_rdata  out  32  word read at the access edge (pre-write contents).
- resp_valid  out  1  one-cycle pulse: access completed.
- busy  out  1  stall request to the core.
- addr_err  out  1  one-cycle pulse with resp_valid: address out of range.

Behaviour:
- Reset (rst=1 at an edge):
  - resp_rdata=0, resp_valid=0, addr_err=0, state=IDLE, counter=0.
  - Any pending request is discarded; no RAM write occurs for it.
  - RAM contents are not reset.
- Word index = req_addr[ADDR_W+1:2].
- In range when req_addr[31:ADDR_W+2]==0. Out of range:
  - no RAM write;
  - resp_rdata=0;
  - addr_err=1 alongside resp_valid.
- Access, performed at a single edge:
  - resp_rdata <= mem[idx];
  - for each i with wen[i]=1, mem[idx] byte i <= wdata byte i;
  - resp_valid <= 1.
- resp_valid and addr_err are single-cycle pulses: they clear at the next edge unless another access completes there.
- WAIT_CYCLES=0:
  - No FSM wait; busy is constant 0.
  - req_en=1 at edge t performs the access at edge t; resp_valid is high in cycle t+1.
  - Back-to-back requests give one response per cycle.
- WAIT_CYCLES=W>0, FSM with states IDLE and WAIT:
  - IDLE, req_en=1 at edge t: latch wen, addr, wdata; cnt <= W-1; go to WAIT.
  - WAIT, cnt!=0 at an edge: cnt <= cnt-1.
  - WAIT, cnt==0 at an edge: perform the access from the latched fields; go to IDLE.
  - Net timing: access at edge t+W; resp_valid high in cycle t+W+1.
  - busy = (state==WAIT) | (state==IDLE & req_en). It is combinational, so the core stalls in the request cycle itself.
  - busy is high for exactly W+1 cycles and is 0 in the resp_valid cycle.
  - Request inputs are ignored while in WAIT; latched values are used.
  - A new request may be accepted in the resp_valid cycle.
- Counter width: 4 bits.
- Simultaneous rst and a completing access: reset wins; no RAM write, no response.
- A partial write returns the old word on resp_rdata; the core ignores it.
- Implementation is a single always block for RAM plus FSM/counter; no combinational path from req_* to resp_*.

Test Plan:
1. W=0, ADDR_W=10:
   - Write addr 0x10, wen 1111, data 0xDEADBEEF.
   - Next cycle read 0x10.
   - Expect resp_valid in cycle after each request; read returns 0xDEADBEEF; busy 0 throughout.
2. W=0, byte-lane write after test 1:
   - Write addr 0x13 (bits [1:0] ignored), wen 0010, data 0x0000AB00.
   - Read 0x10.
   - Expect resp_rdata 0xDEADABEF.
3. W=3, read 0x10 at edge t:
   - Expect busy=1 during cycles t..t+3 (4 cycles).
   - Expect resp_valid only in cycle t+4 with 0xDEADABEF.
   - Toggle req_addr/req_wen during WAIT: expect no effect on result or RAM.
4. Out of range, ADDR_W=10:
   - Write 0x00001000, wen 1111, data 0x12345678.
   - Expect resp_valid=1 and addr_err=1 for one cycle, resp_rdata=0.
   - Read of word 0 shows its prior value unchanged.
5. Reset mid-operation, W=3:
   - Issue write 0x20, data 0xCAFEF00D; assert rst on the second WAIT cycle.
   - Expect next cycle busy=0, resp_valid=0.
   - A subsequent read of 0x20 returns the pre-test value.
6. W=0, streaming reads of 0x0, 0x4, 0x8, 0xC on consecutive cycles:
   - Expect four consecutive resp_valid pulses with the matching words, in order, busy never asserted.
